score_display: RTL

//  Display-side consumer of the game score: converts the binary score from get_score into
//  BCD with a sequential shift-add-3 engine and drives the 4-digit multiplexed
//  7-segment display (AN/seg) of the pinball board.

---
 rtl/score_display_pkg.sv | 43 ++++
 rtl/score_display_if.sv | 14 +
 rtl/score_display_bin2bcd.sv | 81 ++++++++
 rtl/score_display.sv | 98 +++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// Shared constants for the score display: active-low 7-segment codes, digit-enable idle
// pattern, converter state encoding and the nibble-to-segment decoder.
package score_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } conv_state_t;

  // Non-decimal nibbles cannot occur after a valid conversion; show them blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/score_display_if.sv
// Score-side and board-side signals of the score display, grouped with the
// driver (master) and display (slave) views.
interface score_display_if #(
  parameter int SCORE_W = 15
);
  logic [SCORE_W-1:0] score;
  logic               blink;
  logic               busy;
  logic [3:0]         AN;
  logic [6:0]         seg;

  modport master (output score, blink, input busy, AN, seg);
  modport slave  (input score, blink, output busy, AN, seg);
endinterface

// File: rtl/score_display_bin2bcd.sv
// Sequential shift-add-3 binary to 5-digit BCD converter, one bit per cycle.
// busy rises on start and falls as the DONE cycle ends; done marks the DONE cycle.
module bin2bcd_seq
  import score_display_pkg::*;
#(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic [19:0]  bcd
);

  localparam int CNT_W = $clog2(W + 1);

  conv_state_t      r_state;
  logic [W-1:0]     r_bin;
  logic [19:0]      r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [19:0]      w_adj;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ? r_bcd[4*gi +: 4] + 4'd3
                                                           : r_bcd[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_bin   <= bin;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(W);
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {r_bcd, r_bin} <= {w_adj[18:0], r_bin, 1'b0};
          r_cnt          <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: rtl/score_display.sv
// Score display: reconverts the score whenever it differs from the last converted value,
// saturates at 9999, and scans four active-low digits with leading-zero blank and blink.
module score_display
  import score_display_pkg::*;
#(
  parameter int SCORE_W   = 15,
  parameter int SCAN_DIV  = 17,
  parameter int BLINK_DIV = 24,
  parameter bit LZ_BLANK  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  score_display_if.slave  disp
);

  logic [SCORE_W-1:0]   r_last;
  logic [SCORE_W-1:0]   r_capt;
  logic [15:0]          r_digits;
  logic [SCAN_DIV-1:0]  r_scan;
  logic [BLINK_DIV-1:0] r_blink_cnt;
  logic [3:0]           r_an;
  logic [6:0]           r_seg;

  logic        w_busy;
  logic        w_done;
  logic [19:0] w_bcd;
  logic        w_start;
  logic        w_sat;
  logic [15:0] w_digits_next;
  logic [3:0]  w_lit;
  logic [1:0]  w_sel;
  logic [3:0]  w_cur_digit;
  logic        w_off;

  bin2bcd_seq #(.W(SCORE_W)) u_conv (
    .clk   (clk),
    .reset (reset),
    .start (w_start),
    .bin   (disp.score),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  // busy stays high through DONE, so !busy means the converter is idle.
  assign w_start = (disp.score != r_last) && !w_busy;
  assign w_sat   = (w_bcd[19:16] != 4'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign w_digits_next[4*gi +: 4] = w_sat ? 4'd9 : w_bcd[4*gi +: 4];
      if (gi == 0) begin : g_units
        assign w_lit[gi] = 1'b1;
      end else begin : g_upper
        assign w_lit[gi] = !LZ_BLANK || (r_digits[15:4*gi] != '0);
      end
    end
  endgenerate

  assign w_sel       = r_scan[SCAN_DIV-1 -: 2];
  assign w_cur_digit = r_digits[{w_sel, 2'b00} +: 4];
  assign w_off       = (disp.blink && r_blink_cnt[BLINK_DIV-1]) || !w_lit[w_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last      <= '0;
      r_capt      <= '0;
      r_digits    <= '0;
      r_scan      <= '0;
      r_blink_cnt <= '0;
      r_an        <= AN_OFF;
      r_seg       <= SEG_BLANK;
    end else begin
      r_scan      <= r_scan + SCAN_DIV'(1);
      r_blink_cnt <= r_blink_cnt + BLINK_DIV'(1);
      if (w_start) begin
        r_capt <= disp.score;
      end
      if (w_done) begin
        r_last   <= r_capt;
        r_digits <= w_digits_next;
      end
      if (w_off) begin
        r_an  <= AN_OFF;
        r_seg <= SEG_BLANK;
      end else begin
        r_an  <= ~(4'b0001 << w_sel);
        r_seg <= seg_decode(w_cur_digit);
      end
    end
  end

  assign disp.busy = w_busy;
  assign disp.AN   = r_an;
  assign disp.seg  = r_seg;

endmodule
